// File: rtl/ddsm_fcw_ramp_ctrl.sv
// FCW ramp sequencer for the DDSM: walks the modulator word from its current value to a
// host target in fixed-dwell steps and signals completion after the alignment latency.
module ddsm_fcw_ramp_ctrl #(
  parameter int unsigned P_DWELL    = 4,
  parameter logic [23:0] P_INIT_FCW = 24'h000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [23:0] i_target,
  input  logic [23:0] i_step,
  input  logic        i_abort,
  output logic [7:0]  o_msb,
  output logic [7:0]  o_isb,
  output logic [7:0]  o_lsb,
  output logic        o_upd,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_SETTLE
  } state_t;

  localparam logic [15:0] DWELL_RELOAD = 16'(P_DWELL - 1);

  state_t      state, state_nx;
  logic [23:0] cur, cur_nx;
  logic [23:0] tgt, tgt_nx;
  logic [23:0] stp, stp_nx;
  logic [15:0] dcnt, dcnt_nx;
  logic        scnt, scnt_nx;
  logic        upd, upd_nx;
  logic        done, done_nx;

  // Next ramp value; 25-bit intermediates keep the clamp free of wrap-around.
  logic [24:0] sum;
  logic [24:0] gap;
  logic [23:0] step_val;

  always_comb begin
    sum = {1'b0, cur} + {1'b0, stp};
    gap = {1'b0, cur} - {1'b0, tgt};
    if (stp == 24'd0) begin
      step_val = tgt;
    end else if (cur < tgt) begin
      step_val = (sum >= {1'b0, tgt}) ? tgt : sum[23:0];
    end else if (cur > tgt) begin
      step_val = ({1'b0, stp} >= gap) ? tgt : (cur - stp);
    end else begin
      step_val = tgt;
    end
  end

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path infers a latch.
    state_nx = state;
    cur_nx   = cur;
    tgt_nx   = tgt;
    stp_nx   = stp;
    dcnt_nx  = dcnt;
    scnt_nx  = scnt;
    upd_nx   = 1'b0;
    done_nx  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (i_req_valid) begin
          tgt_nx   = i_target;
          stp_nx   = i_step;
          dcnt_nx  = 16'd0;
          state_nx = S_RAMP;
        end
      end

      S_RAMP: begin
        if (i_abort) begin
          state_nx = S_IDLE;
        end else if (dcnt == 16'd0) begin
          cur_nx  = step_val;
          upd_nx  = 1'b1;
          dcnt_nx = DWELL_RELOAD;
          if (step_val == tgt) begin
            state_nx = S_SETTLE;
            scnt_nx  = 1'b0;
          end
        end else begin
          dcnt_nx = dcnt - 16'd1;
        end
      end

      // Two cycles here cover the msb alignment delay downstream.
      S_SETTLE: begin
        if (i_abort) begin
          state_nx = S_IDLE;
        end else if (!scnt) begin
          scnt_nx = 1'b1;
        end else begin
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cur   <= P_INIT_FCW;
      tgt   <= P_INIT_FCW;
      stp   <= 24'd0;
      dcnt  <= 16'd0;
      scnt  <= 1'b0;
      upd   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
      tgt   <= tgt_nx;
      stp   <= stp_nx;
      dcnt  <= dcnt_nx;
      scnt  <= scnt_nx;
      upd   <= upd_nx;
      done  <= done_nx;
    end
  end

  // All three lanes come from the one cur register, so bytes never skew.
  assign o_msb       = cur[23:16];
  assign o_isb       = cur[15:8];
  assign o_lsb       = cur[7:0];
  assign o_upd       = upd;
  assign o_done      = done;
  assign o_req_ready = (state == S_IDLE);
  assign o_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ddsm_fcw_ramp_ctrl.sv
// Directed bench for ddsm_fcw_ramp_ctrl: table of ramps plus hand sequences for abort,
// back-to-back requests and reset during SETTLE.
module tb_ddsm_fcw_ramp_ctrl;

  localparam int          DWELL = 4;
  localparam logic [23:0] INIT  = 24'h123456;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] target = '0;
  logic [23:0] step = '0;
  logic        abort = 1'b0;
  logic [7:0]  msb, isb, lsb;
  logic        upd, busy, done;

  int checks = 0;
  int errors = 0;

  ddsm_fcw_ramp_ctrl #(.P_DWELL(DWELL), .P_INIT_FCW(INIT)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_target   (target),
    .i_step     (step),
    .i_abort    (abort),
    .o_msb      (msb),
    .o_isb      (isb),
    .o_lsb      (lsb),
    .o_upd      (upd),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] start;
    logic [23:0] tgt;
    logic [23:0] stp;
    int          n;
    logic [23:0] v [3];
  } vec_t;

  vec_t vecs [6];

  function automatic logic [23:0] lanes();
    return {msb, isb, lsb};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] t, input logic [23:0] s);
    int w = 0;
    while (!req_ready && w < 100) begin
      tick();
      w++;
    end
    check("ready before request", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    target    = t;
    step      = s;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_ramp(input string name, input logic [23:0] t, input logic [23:0] s,
                          input int n, input logic [23:0] v [3]);
    int          k = 0, last = 0, nupd = 0, glitch = 0, idle_mid = 0;
    logic        seen = 1'b0;
    logic [23:0] prev;
    logic [23:0] got [3];
    got = '{24'h0, 24'h0, 24'h0};
    send(t, s);
    prev = lanes();
    while (!seen && k < 200) begin
      tick();
      k++;
      if (upd) begin
        if (nupd == 0) check({name, " first upd latency"}, k, 1);
        else           check({name, " upd spacing"}, k - last, DWELL);
        if (nupd < 3) got[nupd] = lanes();
        nupd++;
        last = k;
      end else if (lanes() !== prev) begin
        glitch++;
      end
      prev = lanes();
      if (done) begin
        seen = 1'b1;
        check({name, " done delay"}, k - last, 2);
        check({name, " ready at done"}, 32'(req_ready), 32'd1);
        check({name, " busy at done"}, 32'(busy), 32'd0);
      end else if (!busy) begin
        idle_mid++;
      end
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
    check({name, " upd count"}, nupd, n);
    for (int i = 0; i < n && i < 3; i++) check({name, " value"}, 32'(got[i]), 32'(v[i]));
    check({name, " lanes stable between upd"}, glitch, 0);
    check({name, " busy through ramp"}, idle_mid, 0);
  endtask

  task automatic jump_to(input logic [23:0] v);
    logic [23:0] e [3];
    e = '{v, 24'h0, 24'h0};
    run_ramp("prep", v, 24'h0, 1, e);
  endtask

  task automatic set_vec(input int i, input string nm, input logic [23:0] st, input logic [23:0] t,
                         input logic [23:0] s, input int n, input logic [23:0] a,
                         input logic [23:0] b, input logic [23:0] c);
    vecs[i].name  = nm;
    vecs[i].start = st;
    vecs[i].tgt   = t;
    vecs[i].stp   = s;
    vecs[i].n     = n;
    vecs[i].v     = '{a, b, c};
  endtask

  initial begin
    int   nupd, k;
    logic seen_bad;

    set_vec(0, "direct jump", 24'h000000, 24'hABCDEF, 24'h000000, 1, 24'hABCDEF, 24'h0, 24'h0);
    set_vec(1, "up clamp",    24'h000000, 24'h00000A, 24'h000004, 3, 24'h000004, 24'h000008, 24'h00000A);
    set_vec(2, "down clamp",  24'hFFFFFF, 24'hFFFFF0, 24'h000006, 3, 24'hFFFFF9, 24'hFFFFF3, 24'hFFFFF0);
    set_vec(3, "no overflow", 24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFF, 1, 24'hFFFFFF, 24'h0, 24'h0);
    set_vec(4, "equal",       24'h000100, 24'h000100, 24'h000005, 1, 24'h000100, 24'h0, 24'h0);
    set_vec(5, "down to zero",24'h000010, 24'h000000, 24'h000007, 3, 24'h000009, 24'h000002, 24'h000000);

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset lanes", 32'(lanes()), 32'(INIT));
    check("reset ready", 32'(req_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset upd", 32'(upd), 32'd0);
    check("reset done", 32'(done), 32'd0);

    // abort ignored in IDLE
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort in idle lanes", 32'(lanes()), 32'(INIT));
    check("abort in idle ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      jump_to(vecs[i].start);
      run_ramp(vecs[i].name, vecs[i].tgt, vecs[i].stp, vecs[i].n, vecs[i].v);
      check({vecs[i].name, " final lanes"}, 32'(lanes()), 32'(vecs[i].tgt));
    end

    // Abort after the 3rd update, with a stray request during busy
    jump_to(24'h000000);
    send(24'h000064, 24'h00000A);
    nupd = 0;
    k    = 0;
    while (nupd < 3 && k < 100) begin
      tick();
      k++;
      req_valid = 1'b0;
      if (upd) begin
        nupd++;
        check("abort ramp value", 32'(lanes()), 32'(nupd * 10));
        if (nupd == 1) begin
          req_valid = 1'b1;
          target    = 24'hFFFFFF;
          step      = 24'h0;
        end
      end
    end
    check("abort third upd reached", nupd, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort ready", 32'(req_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort upd", 32'(upd), 32'd0);
    check("abort lanes hold", 32'(lanes()), 32'h00001E);
    seen_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (upd || done || lanes() !== 24'h00001E) seen_bad = 1'b1;
    end
    check("abort no later upd/done", 32'(seen_bad), 32'd0);

    // Back-to-back: request held through the done cycle is accepted there
    send(24'h000040, 24'h0);
    req_valid = 1'b1;
    target    = 24'h000050;
    step      = 24'h0;
    tick();
    check("b2b first upd", 32'(upd), 32'd1);
    check("b2b first lanes", 32'(lanes()), 32'h000040);
    tick();
    check("b2b settle ready", 32'(req_ready), 32'd0);
    tick();
    check("b2b done", 32'(done), 32'd1);
    check("b2b ready at done", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("b2b accepted busy", 32'(busy), 32'd1);
    check("b2b accepted upd", 32'(upd), 32'd0);
    tick();
    check("b2b second upd", 32'(upd), 32'd1);
    check("b2b second lanes", 32'(lanes()), 32'h000050);
    tick();
    tick();
    check("b2b second done", 32'(done), 32'd1);

    // Reset during SETTLE discards the ramp with no done pulse
    send(24'h000077, 24'h0);
    tick();
    check("rst-settle upd", 32'(upd), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst-settle lanes", 32'(lanes()), 32'(INIT));
    check("rst-settle done", 32'(done), 32'd0);
    check("rst-settle ready", 32'(req_ready), 32'd1);
    check("rst-settle busy", 32'(busy), 32'd0);
    tick();
    check("rst-settle no late done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
